// File: rtl/sfifo_uart_tx.sv
// sfifo_uart_tx: pops words from an upstream FIFO and sends each as a start/data/stop UART-style frame.
// Define SFIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module sfifo_uart_tx #(
  parameter int Width      = 8,
  parameter int ClksPerBit = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             TxEnable,
  input  logic             FIFOEmpty,
  input  logic [Width-1:0] RDData,
  output logic             FIFORdReq,
  output logic             TxD,
  output logic             TxBusy,
  output logic             FrameDone
);
  localparam int TW = $clog2(ClksPerBit);
  localparam int IW = $clog2(Width + 1);
  localparam logic [TW-1:0] TLAST = TW'(ClksPerBit - 1);
  localparam logic [IW-1:0] ILAST = IW'(Width - 1);
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_START, S_DATA,
`ifdef SFIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
`ifdef SFIFO_UART_TX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [IW-1:0] idx, idx_n;
  logic [Width-1:0] shreg, shreg_n;
  logic go, last, txd_n;
  assign go   = TxEnable & ~FIFOEmpty;
  assign last = timer == TLAST;
`ifdef SFIFO_UART_TX_PARITY_EN
  // parity is taken from the word as captured, since the shift register is consumed by DATA
  logic par;
  always_ff @(posedge clk or posedge reset)
    if (reset) par <= 1'b0;
    else if (state == S_WAIT) par <= ^RDData;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  always_comb begin
    state_n = state;
    idx_n   = idx;
    shreg_n = shreg;
    timer_n = (state == S_IDLE || state == S_REQ || state == S_WAIT || last) ? '0 : timer + 1'b1;
    case (state)
      S_IDLE:  state_n = go ? S_REQ : S_IDLE;
      S_REQ:   state_n = S_WAIT;
      S_WAIT: begin
        state_n = S_START;
        shreg_n = RDData;
      end
      S_START: if (last) begin
        state_n = S_DATA;
        idx_n   = '0;
      end
      S_DATA: if (last) begin
        shreg_n = shreg >> 1;
        idx_n   = idx + 1'b1;
        state_n = idx == ILAST ? S_AFTER_DATA : S_DATA;
      end
`ifdef SFIFO_UART_TX_PARITY_EN
      S_PARITY: state_n = last ? S_STOP : S_PARITY;
`endif
      S_STOP:  state_n = last ? (go ? S_REQ : S_IDLE) : S_STOP;
      default: state_n = S_IDLE;
    endcase
  end
  // outputs are decoded from the next state and registered so they line up with the state itself
  always_comb begin
    txd_n = state_n == S_START ? 1'b0 : state_n == S_DATA ? shreg_n[0] : 1'b1;
`ifdef SFIFO_UART_TX_PARITY_EN
    if (state_n == S_PARITY) txd_n = par;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      TxD       <= 1'b1;
      FIFORdReq <= 1'b0;
      TxBusy    <= 1'b0;
      FrameDone <= 1'b0;
    end else begin
      TxD       <= txd_n;
      FIFORdReq <= state_n == S_REQ;
      TxBusy    <= state_n != S_IDLE;
      FrameDone <= state_n == S_STOP && timer_n == TLAST;
    end
endmodule

// File: tb/tb_sfifo_uart_tx.sv
// tb_sfifo_uart_tx: randomized bench with a frame-level output schedule model and a bench-side FIFO.
module tb_sfifo_uart_tx;
  localparam int W = 8;
`ifdef SFIFO_UART_TX_PARITY_EN
  localparam int CPB = 4;
`else
  localparam int CPB = 16;
`endif
  logic clk = 0, reset = 1, TxEnable = 0, FIFOEmpty = 1;
  logic [W-1:0] RDData = '0;
  logic FIFORdReq, TxD, TxBusy, FrameDone;
  int compared = 0, mismatched = 0, cyc = 0;
  logic [W-1:0] fifo_q[$], pending[$];
  logic [3:0] sched[$];
  int req_q[$], fall_q[$], done_q[$];
  bit txd_hist[int];
  logic prev_txd = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sfifo_uart_tx #(.Width(W), .ClksPerBit(CPB)) dut (
    .clk(clk), .reset(reset), .TxEnable(TxEnable), .FIFOEmpty(FIFOEmpty), .RDData(RDData),
    .FIFORdReq(FIFORdReq), .TxD(TxD), .TxBusy(TxBusy), .FrameDone(FrameDone)
  );

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // expected {TxD,FIFORdReq,TxBusy,FrameDone} for every cycle of one frame, REQ through STOP
  task automatic add_frame(logic [W-1:0] w);
    sched.push_back(4'b1110);
    sched.push_back(4'b1010);
    repeat (CPB) sched.push_back(4'b0010);
    for (int i = 0; i < W; i++) repeat (CPB) sched.push_back({w[i], 3'b010});
`ifdef SFIFO_UART_TX_PARITY_EN
    repeat (CPB) sched.push_back({^w, 3'b010});
`endif
    repeat (CPB - 1) sched.push_back(4'b1010);
    sched.push_back(4'b1011);
  endtask

  // model + FIFO: a new frame is scheduled whenever nothing is pending and a word is available
  always @(posedge clk or posedge reset) begin
    if (reset) sched.delete();
    else begin
      if (sched.size() != 0) void'(sched.pop_front());
      if (sched.size() == 0 && TxEnable && fifo_q.size() != 0) add_frame(fifo_q[0]);
      if (FIFORdReq) begin
        compared++;
        if (fifo_q.size() == 0) begin
          mismatched++;
          $display("FAIL pop_on_empty: cycle %0d got a pop required none", cyc);
        end else RDData <= fifo_q.pop_front();
      end else RDData <= W'($urandom);
      while (pending.size() != 0) fifo_q.push_back(pending.pop_front());
      FIFOEmpty <= fifo_q.size() == 0;
    end
  end

  always @(negedge clk) if (!reset) begin
    logic [3:0] e;
    e = sched.size() != 0 ? sched[0] : 4'b1000;
    compared++;
    if ({TxD, FIFORdReq, TxBusy, FrameDone} !== e) begin
      mismatched++;
      $display("FAIL outputs cycle %0d {txd,req,busy,done}: got %b expected %b",
               cyc, {TxD, FIFORdReq, TxBusy, FrameDone}, e);
    end
    if (FIFORdReq) req_q.push_back(cyc);
    if (prev_txd && !TxD) fall_q.push_back(cyc);
    if (FrameDone) done_q.push_back(cyc);
    txd_hist[cyc] = TxD;
    prev_txd = TxD;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear();
    req_q.delete();
    fall_q.delete();
    done_q.delete();
  endtask

  task automatic wait_for(int which, int n, string name);
    for (int i = 0; i < 3000; i++) begin
      if ((which == 0 ? req_q.size() : which == 1 ? fall_q.size() : done_q.size()) >= n) return;
      tick(1);
    end
    compared++;
    mismatched++;
    $display("FAIL %s: timed out, got fewer than %0d events required", name, n);
  endtask

  initial begin
    logic [9:0] bits;
    int r;
    tick(2);
    reset = 0;
    // T1: asynchronous reset in the middle of a frame
    pending.push_back(8'h5A);
    TxEnable = 1;
    tick(4 * CPB);
    #1 reset = 1;
    #1;
    chk("t1_txd", TxD, 1);
    chk("t1_busy", TxBusy, 0);
    chk("t1_req", FIFORdReq, 0);
    chk("t1_done", FrameDone, 0);
    tick(2);
    reset = 0;
    clear();
    tick(30);
    chk("t1_no_pop", req_q.size(), 0);
    chk("t1_idle", TxBusy, 0);
`ifndef SFIFO_UART_TX_PARITY_EN
    // T2: single word 0xA5
    clear();
    pending.push_back(8'hA5);
    wait_for(2, 1, "t2_done");
    chk("t2_reqs", req_q.size(), 1);
    chk("t2_req_to_fall", fall_q[0] - req_q[0], 2);
    chk("t2_frame_len", done_q[0] - fall_q[0] + 1, 160);
    for (int k = 0; k < 10; k++) bits[k] = txd_hist[fall_q[0] + 16 * k + 8];
    chk("t2_bits", bits, 10'b1101001010);
    // T3: back-to-back frames
    tick(5);
    clear();
    pending.push_back(8'h00);
    pending.push_back(8'hFF);
    pending.push_back(8'h3C);
    wait_for(2, 3, "t3_done");
    tick(10);
    chk("t3_reqs", req_q.size(), 3);
    chk("t3_gap1", fall_q[1] - done_q[0], 3);
    chk("t3_gap2", fall_q[2] - done_q[1], 3);
    chk("t3_idle", TxBusy, 0);
    // T4: TxEnable dropped mid-frame
    TxEnable = 0;
    tick(5);
    clear();
    pending.push_back(8'h11);
    pending.push_back(8'h22);
    tick(3);
    TxEnable = 1;
    wait_for(1, 1, "t4_fall");
    tick(40);
    TxEnable = 0;
    tick(400);
    chk("t4_reqs", req_q.size(), 1);
    chk("t4_dones", done_q.size(), 1);
    r = cyc;
    TxEnable = 1;
    wait_for(0, 2, "t4_req2");
    chk("t4_restart", req_q[1] - r, 1);
    wait_for(2, 2, "t4_done2");
    // T5: empty guard and a word arriving mid-frame
    tick(5);
    clear();
    tick(1000);
    chk("t5_reqs", req_q.size(), 0);
    chk("t5_falls", fall_q.size(), 0);
    pending.push_back(8'h96);
    wait_for(1, 1, "t5_fall");
    tick(30);
    pending.push_back(8'h69);
    wait_for(2, 2, "t5_done2");
    chk("t5_reqs2", req_q.size(), 2);
    chk("t5_after_stop", req_q[1] - done_q[0], 1);
`else
    // T6: parity frames with ClksPerBit=4
    clear();
    pending.push_back(8'h07);
    pending.push_back(8'h03);
    wait_for(2, 2, "t6_done");
    chk("t6_frame_len", done_q[0] - fall_q[0] + 1, 44);
    chk("t6_par_07", txd_hist[fall_q[0] + 4 * 9 + 2], 1);
    chk("t6_par_03", txd_hist[fall_q[1] + 4 * 9 + 2], 0);
    chk("t6_gap", fall_q[1] - done_q[0], 3);
`endif
    // randomized traffic, enable toggling and occasional resets
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      if ($urandom_range(0, 199) == 0) pending.push_back(8'($urandom));
      if ($urandom_range(0, 79) == 0) TxEnable = ~TxEnable;
      if ($urandom_range(0, 1499) == 0) begin
        #4 reset = 1;
        #1;
        chk("rnd_reset_txd", TxD, 1);
        chk("rnd_reset_busy", TxBusy, 0);
        @(posedge clk);
        #2 reset = 0;
      end
    end
    TxEnable = 1;
    for (int i = 0; i < 20000 && (fifo_q.size() != 0 || pending.size() != 0 || sched.size() != 0); i++) tick(1);
    tick(3);
    chk("drain_idle", TxBusy, 0);
    chk("drain_fifo", fifo_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
